md_unit_iter: RTL and testbench

- Parametrised HI/LO multiply/divide unit for the MIPS pipeline; successor to the fixed-latency 32-bit MD unit.
- Sits in the EX stage: the stall logic consumes start/busy, and mfhi/mflo read md_out.
- Adds a configurable width and multiply latency, a true iterative restoring divider (WIDTH cycles), multiply-accumulate ops, flush/abort, and defined divide-by-zero and overflow results.

---
 rtl/md_unit_iter_if.sv | 26 ++
 rtl/md_unit_iter.sv | 178 +++++++++++++++++
 tb/tb_md_unit_iter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_iter_if.sv
// rtl/md_unit_iter_if.sv - EX-stage bundle between the pipeline and the HI/LO multiply/divide unit
interface md_unit_iter_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       md_op;
    logic             flush;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] md_out;

    // Pipeline side: issues ops and operands, observes stall and HI/LO.
    modport master (
        output md_op, flush, rs, rt,
        input  start, busy, hi, lo, md_out
    );

    // Unit side.
    modport slave (
        input  md_op, flush, rs, rt,
        output start, busy, hi, lo, md_out
    );
endinterface

// File: rtl/md_unit_iter.sv
// rtl/md_unit_iter.sv - parametrised HI/LO multiply/divide unit with iterative restoring divider
module md_unit_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic          clk,
    input  logic          reset,
    md_unit_iter_if.slave bus
);
    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [3:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;      // raw rs: multiplicand, or dividend for the /0 and overflow results
    logic [WIDTH-1:0] r_b;      // multiplier, or |divisor|
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [WIDTH-1:0] r_quo;    // dividend bits shift out the top while quotient bits shift in
    logic             r_qneg;
    logic             r_rneg;
    logic             r_dz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Issue decode
    logic             w_start;
    logic             w_is_div;
    logic             w_div_signed;
    logic             w_rs_neg;
    logic             w_rt_neg;
    logic [WIDTH-1:0] w_rs_abs;
    logic [WIDTH-1:0] w_rt_abs;

    assign w_start      = !bus.flush && (((bus.md_op >= 4'd1) && (bus.md_op <= 4'd4)) ||
                                         ((bus.md_op >= 4'd9) && (bus.md_op <= 4'd12)));
    assign w_is_div     = (bus.md_op == 4'd3) || (bus.md_op == 4'd4);
    assign w_div_signed = (bus.md_op == 4'd3);
    assign w_rs_neg     = w_div_signed & bus.rs[WIDTH-1];
    assign w_rt_neg     = w_div_signed & bus.rt[WIDTH-1];
    assign w_rs_abs     = w_rs_neg ? -bus.rs : bus.rs;
    assign w_rt_abs     = w_rt_neg ? -bus.rt : bus.rt;

    // Multiply: sign- or zero-extended operands, product taken mod 2^(2*WIDTH)
    logic                 w_mul_signed;
    logic [2*WIDTH-1:0]   w_ext_a;
    logic [2*WIDTH-1:0]   w_ext_b;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_mul_res;

    assign w_mul_signed = (r_op == 4'd1) || (r_op == 4'd9) || (r_op == 4'd11);
    assign w_ext_a      = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_ext_b      = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod       = w_ext_a * w_ext_b;
    assign w_mul_res    = ((r_op == 4'd9) || (r_op == 4'd10)) ? ({r_hi, r_lo} + w_prod) :
                          ((r_op == 4'd11) || (r_op == 4'd12)) ? ({r_hi, r_lo} - w_prod) : w_prod;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // When the subtraction fits, the true difference is below the divisor, so W bits suffice.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_b});
    assign w_diff   = w_shift[WIDTH-1:0] - r_b;
    assign w_rem_nx = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};
    assign w_q_fin  = r_qneg ? -w_quo_nx : w_quo_nx;
    assign w_r_fin  = r_rneg ? -w_rem_nx : w_rem_nx;

    assign bus.start = w_start;
    assign bus.busy  = (r_state != S_IDLE);
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;

    // mfhi/mflo read port; decodes regardless of busy
    always_comb begin
        bus.md_out = '0;
        if (bus.md_op == 4'd5)
            bus.md_out = r_hi;
        else if (bus.md_op == 4'd6)
            bus.md_out = r_lo;
    end

    // Control FSM, iteration datapath and HI/LO write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op  <= bus.md_op;
                        r_cnt <= '0;
                        r_a   <= bus.rs;
                        r_rem <= '0;
                        if (w_is_div) begin
                            r_state <= S_DIV;
                            r_b     <= w_rt_abs;
                            r_quo   <= w_rs_abs;
                            r_qneg  <= w_rs_neg ^ w_rt_neg;
                            r_rneg  <= w_rs_neg;
                            r_dz    <= (bus.rt == '0);
                            r_ovf   <= w_div_signed && (bus.rs == MOST_NEG) && (bus.rt == '1);
                        end else begin
                            r_state <= S_MUL;
                            r_b     <= bus.rt;
                        end
                    end else if (!bus.flush && (bus.md_op == 4'd7)) begin
                        r_hi <= bus.rs;
                    end else if (!bus.flush && (bus.md_op == 4'd8)) begin
                        r_lo <= bus.rs;
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == MUL_LAST) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        if (r_cnt == DIV_LAST) begin
                            r_state <= S_IDLE;
                            if (r_dz) begin
                                r_lo <= '1;
                                r_hi <= r_a;
                            end else if (r_ovf) begin
                                r_lo <= r_a;
                                r_hi <= '0;
                            end else begin
                                r_lo <= w_q_fin;
                                r_hi <= w_r_fin;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_unit_iter.sv
// tb/tb_md_unit_iter.sv - self-checking bench for md_unit_iter at WIDTH 32/MUL_LAT 5 and WIDTH 16/MUL_LAT 1
module tb_md_unit_iter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_iter_if #(.WIDTH(32)) if32();
    md_unit_iter_if #(.WIDTH(16)) if16();

    md_unit_iter #(.WIDTH(32), .MUL_LAT(5)) u32 (.clk(clk), .reset(reset), .bus(if32.slave));
    md_unit_iter #(.WIDTH(16), .MUL_LAT(1)) u16 (.clk(clk), .reset(reset), .bus(if16.slave));

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m32_hi, m32_lo, m16_hi, m16_lo;

    function automatic logic [63:0] msk(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint sx(input logic [63:0] v, input int w);
        return v[w-1] ? (longint'(v) - (longint'(1) <<< w)) : longint'(v);
    endfunction

    function automatic int exp_lat(input bit w16, input logic [3:0] op);
        if ((op >= 4'd1 && op <= 4'd2) || (op >= 4'd9 && op <= 4'd12)) return w16 ? 1 : 5;
        if (op == 4'd3 || op == 4'd4) return w16 ? 16 : 32;
        return 0;
    endfunction

    // Architectural reference: HI/LO as one 2W-bit accumulator, plain integer arithmetic.
    task automatic model(input int w, input logic [3:0] op, input logic [31:0] a_i, input logic [31:0] b_i,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        logic [63:0] m, m2, a, b, acc, prod;
        longint q, r;
        m = msk(w); m2 = msk(2*w);
        a = 64'(a_i) & m; b = 64'(b_i) & m;
        acc = ((64'(hi) << w) | 64'(lo)) & m2;
        if (op == 4'd1 || op == 4'd9 || op == 4'd11) begin
            q = sx(a, w) * sx(b, w);
            prod = 64'(q) & m2;
        end else begin
            prod = (a * b) & m2;
        end
        case (op)
            4'd1, 4'd2: acc = prod;
            4'd9, 4'd10: acc = (acc + prod) & m2;
            4'd11, 4'd12: acc = (acc - prod) & m2;
            default: ;
        endcase
        if (op inside {4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12}) begin
            hi = 32'((acc >> w) & m);
            lo = 32'(acc & m);
        end else if (op == 4'd3 || op == 4'd4) begin
            if (b == 0) begin
                lo = 32'(m); hi = 32'(a);
            end else if (op == 4'd3 && a == (64'd1 << (w-1)) && b == m) begin
                lo = 32'(a); hi = 32'd0;
            end else if (op == 4'd3) begin
                q = sx(a, w) / sx(b, w);
                r = sx(a, w) % sx(b, w);
                lo = 32'(64'(q) & m); hi = 32'(64'(r) & m);
            end else begin
                lo = 32'(a / b); hi = 32'(a % b);
            end
        end else if (op == 4'd7) begin
            hi = 32'(a);
        end else if (op == 4'd8) begin
            lo = 32'(a);
        end
    endtask

    // Issues one op for a single cycle and counts busy cycles (bounded).
    task automatic run_op(input bit w16, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic st);
        @(negedge clk);
        if (w16) begin if16.md_op = op; if16.rs = a[15:0]; if16.rt = b[15:0]; end
        else     begin if32.md_op = op; if32.rs = a;       if32.rt = b;       end
        #1 st = w16 ? if16.start : if32.start;
        @(negedge clk);
        if16.md_op = 4'd0; if32.md_op = 4'd0;
        lat = 0;
        while ((w16 ? if16.busy : if32.busy) && lat < 200) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m32_hi = 0; m32_lo = 0; m16_hi = 0; m16_lo = 0;
        @(negedge clk);
        n_tests++; if (if32.hi !== 32'd0)   begin n_fail++; $display("FAIL reset_hi32 got %h exp 0", if32.hi); end
        n_tests++; if (if32.lo !== 32'd0)   begin n_fail++; $display("FAIL reset_lo32 got %h exp 0", if32.lo); end
        n_tests++; if (if32.busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy32 got %b exp 0", if32.busy); end
        n_tests++; if (if16.hi !== 16'd0 || if16.lo !== 16'd0 || if16.busy !== 1'b0)
            begin n_fail++; $display("FAIL reset_16 got hi=%h lo=%h busy=%b exp 0", if16.hi, if16.lo, if16.busy); end
    endtask

    task automatic test_mult;
        logic [3:0] ops [2] = '{4'd1, 4'd2};
        logic [31:0] va [2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] vb [2] = '{32'd3, 32'd3};
        logic [31:0] eh [2] = '{32'hFFFF_FFFF, 32'h0000_0002};
        logic [3:0] op; logic [31:0] a, b; int lat; logic st;
        for (int i = 0; i < 10; i++) begin
            if (i < 2) begin op = ops[i]; a = va[i]; b = vb[i]; end
            else begin op = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd2; a = $urandom; b = $urandom; end
            model(32, op, a, b, m32_hi, m32_lo);
            run_op(1'b0, op, a, b, lat, st);
            if (i < 2) begin
                n_tests++; if (if32.hi !== eh[i] || if32.lo !== 32'hFFFF_FFFA)
                    begin n_fail++; $display("FAIL mult_plan%0d got %h_%h exp %h_fffffffa", i, if32.hi, if32.lo, eh[i]); end
            end
            n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL mult_start op=%0d got %b exp 1", op, st); end
            n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL mult_lat op=%0d got %0d exp 5", op, lat); end
            n_tests++; if (if32.hi !== m32_hi || if32.lo !== m32_lo)
                begin n_fail++; $display("FAIL mult op=%0d a=%h b=%h got %h_%h exp %h_%h", op, a, b, if32.hi, if32.lo, m32_hi, m32_lo); end
        end
    endtask

    task automatic test_div;
        logic [3:0] ops [5] = '{4'd3, 4'd4, 4'd3, 4'd3, 4'd4};
        logic [31:0] va [5] = '{32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'h8000_0000, 32'hCAFE_0001};
        logic [31:0] vb [5] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] el [5] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] eh [5] = '{32'hFFFF_FFFF, 32'd2, 32'h1234_5678, 32'd0, 32'hCAFE_0001};
        logic [3:0] op; logic [31:0] a, b; int lat; logic st;
        for (int i = 0; i < 13; i++) begin
            if (i < 5) begin op = ops[i]; a = va[i]; b = vb[i]; end
            else begin
                op = ($urandom_range(0, 1) == 0) ? 4'd3 : 4'd4;
                a = $urandom;
                b = ($urandom_range(0, 1) == 0) ? $urandom : (32'($urandom_range(1, 40)) * (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF));
            end
            model(32, op, a, b, m32_hi, m32_lo);
            run_op(1'b0, op, a, b, lat, st);
            if (i < 5) begin
                n_tests++; if (if32.hi !== eh[i] || if32.lo !== el[i])
                    begin n_fail++; $display("FAIL div_plan%0d got %h_%h exp %h_%h", i, if32.hi, if32.lo, eh[i], el[i]); end
            end
            n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL div_lat op=%0d got %0d exp 32", op, lat); end
            n_tests++; if (if32.hi !== m32_hi || if32.lo !== m32_lo)
                begin n_fail++; $display("FAIL div op=%0d a=%h b=%h got %h_%h exp %h_%h", op, a, b, if32.hi, if32.lo, m32_hi, m32_lo); end
        end
    endtask

    task automatic test_mac;
        logic [3:0] ops [4] = '{4'd7, 4'd8, 4'd10, 4'd11};
        logic [31:0] va [4] = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'd1};
        logic [3:0] op; logic [31:0] a, b; int lat; logic st;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin op = ops[i]; a = va[i]; b = 32'd1; end
            else begin op = 4'(9 + $urandom_range(0, 3)); a = $urandom; b = $urandom; end
            model(32, op, a, b, m32_hi, m32_lo);
            run_op(1'b0, op, a, b, lat, st);
            if (i == 2) begin
                n_tests++; if (if32.hi !== 32'd6 || if32.lo !== 32'd0)
                    begin n_fail++; $display("FAIL maddu_plan got %h_%h exp 00000006_00000000", if32.hi, if32.lo); end
            end
            if (i == 3) begin
                n_tests++; if (if32.hi !== 32'd5 || if32.lo !== 32'hFFFF_FFFF)
                    begin n_fail++; $display("FAIL msub_plan got %h_%h exp 00000005_ffffffff", if32.hi, if32.lo); end
            end
            n_tests++; if (lat !== exp_lat(1'b0, op)) begin n_fail++; $display("FAIL mac_lat op=%0d got %0d exp %0d", op, lat, exp_lat(1'b0, op)); end
            n_tests++; if (if32.hi !== m32_hi || if32.lo !== m32_lo)
                begin n_fail++; $display("FAIL mac op=%0d a=%h b=%h got %h_%h exp %h_%h", op, a, b, if32.hi, if32.lo, m32_hi, m32_lo); end
        end
        @(negedge clk); if32.md_op = 4'd5;
        #1 n_tests++; if (if32.md_out !== m32_hi) begin n_fail++; $display("FAIL mfhi got %h exp %h", if32.md_out, m32_hi); end
        if32.md_op = 4'd6;
        #1 n_tests++; if (if32.md_out !== m32_lo) begin n_fail++; $display("FAIL mflo got %h exp %h", if32.md_out, m32_lo); end
        if32.md_op = 4'd0;
    endtask

    task automatic test_flush;
        int lat, c; logic st;
        logic [31:0] hv, lv;
        hv = $urandom; lv = $urandom;
        model(32, 4'd7, hv, 0, m32_hi, m32_lo);
        run_op(1'b0, 4'd7, hv, 0, lat, st);
        model(32, 4'd8, lv, 0, m32_hi, m32_lo);
        run_op(1'b0, 4'd8, lv, 0, lat, st);
        @(negedge clk); if32.md_op = 4'd3; if32.rs = $urandom; if32.rt = 32'd3;
        @(negedge clk); if32.md_op = 4'd0;
        c = 1;
        while (c < 10) begin
            if (c == 3) begin if32.md_op = 4'd8; if32.rs = 32'hDEAD_BEEF; end
            else if32.md_op = 4'd0;
            @(negedge clk); c++;
        end
        n_tests++; if (if32.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_before got %b exp 1", if32.busy); end
        if32.flush = 1'b1;
        @(negedge clk); if32.flush = 1'b0;
        n_tests++; if (if32.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after got %b exp 0", if32.busy); end
        n_tests++; if (if32.hi !== m32_hi || if32.lo !== m32_lo)
            begin n_fail++; $display("FAIL flush_hilo got %h_%h exp %h_%h", if32.hi, if32.lo, m32_hi, m32_lo); end
        if32.flush = 1'b1; if32.md_op = 4'd1; if32.rs = 32'd9; if32.rt = 32'd9;
        #1 n_tests++; if (if32.start !== 1'b0) begin n_fail++; $display("FAIL flush_idle_start got %b exp 0", if32.start); end
        @(negedge clk); if32.flush = 1'b0; if32.md_op = 4'd0;
        n_tests++; if (if32.busy !== 1'b0 || if32.hi !== m32_hi || if32.lo !== m32_lo)
            begin n_fail++; $display("FAIL flush_idle got busy=%b %h_%h exp busy=0 %h_%h", if32.busy, if32.hi, if32.lo, m32_hi, m32_lo); end
    endtask

    task automatic test_back_to_back;
        logic [10:0] seen; logic [31:0] a, b;
        a = $urandom; b = $urandom;
        @(negedge clk); if32.md_op = 4'd9; if32.rs = a; if32.rt = b;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            seen[10-k] = if32.busy;
            if (k == 6) if32.md_op = 4'd0;
        end
        @(negedge clk); if32.md_op = 4'd0;
        model(32, 4'd9, a, b, m32_hi, m32_lo);
        model(32, 4'd9, a, b, m32_hi, m32_lo);
        n_tests++; if (seen !== 11'b11111_0_11111) begin n_fail++; $display("FAIL b2b_busy got %b exp 11111011111", seen); end
        n_tests++; if (if32.hi !== m32_hi || if32.lo !== m32_lo)
            begin n_fail++; $display("FAIL b2b_hilo got %h_%h exp %h_%h", if32.hi, if32.lo, m32_hi, m32_lo); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); if32.md_op = 4'd1; if32.rs = 32'd7; if32.rt = 32'd9;
        @(negedge clk); if32.md_op = 4'd0;
        @(negedge clk); reset = 1'b1; if32.md_op = 4'd5;
        @(negedge clk); reset = 1'b0;
        m32_hi = 0; m32_lo = 0; m16_hi = 0; m16_lo = 0;
        #1;
        n_tests++; if (if32.md_out !== 32'd0) begin n_fail++; $display("FAIL rst_mid_mfhi got %h exp 0", if32.md_out); end
        n_tests++; if (if32.busy !== 1'b0 || if32.lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid got busy=%b lo=%h exp 0", if32.busy, if32.lo); end
        if32.md_op = 4'd0;
    endtask

    task automatic test_w16;
        logic [3:0] op; logic [31:0] a, b; int lat; logic st;
        logic [3:0] ops [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        logic [31:0] va [4] = '{32'hFFFE, 32'hFFFE, 32'hFFF9, 32'd100};
        logic [31:0] vb [4] = '{32'd3, 32'd3, 32'd2, 32'd7};
        logic [31:0] ex [4] = '{32'hFFFF_FFFA, 32'h0002_FFFA, 32'hFFFF_FFFD, 32'h0002_000E};
        for (int i = 0; i < 12; i++) begin
            if (i < 4) begin op = ops[i]; a = va[i]; b = vb[i]; end
            else begin
                op = ($urandom_range(0, 1) == 0) ? 4'(1 + $urandom_range(0, 3)) : 4'(9 + $urandom_range(0, 3));
                a = $urandom & 32'hFFFF; b = $urandom & 32'hFFFF;
            end
            model(16, op, a, b, m16_hi, m16_lo);
            run_op(1'b1, op, a, b, lat, st);
            if (i < 4) begin
                n_tests++; if ({if16.hi, if16.lo} !== ex[i])
                    begin n_fail++; $display("FAIL w16_plan%0d got %h_%h exp %h", i, if16.hi, if16.lo, ex[i]); end
            end
            n_tests++; if (lat !== exp_lat(1'b1, op)) begin n_fail++; $display("FAIL w16_lat op=%0d got %0d exp %0d", op, lat, exp_lat(1'b1, op)); end
            n_tests++; if ({16'd0, if16.hi} !== m16_hi || {16'd0, if16.lo} !== m16_lo)
                begin n_fail++; $display("FAIL w16 op=%0d a=%h b=%h got %h_%h exp %h_%h", op, a, b, if16.hi, if16.lo, m16_hi, m16_lo); end
        end
    endtask

    initial begin
        reset = 1'b1;
        if32.md_op = 4'd0; if32.flush = 1'b0; if32.rs = '0; if32.rt = '0;
        if16.md_op = 4'd0; if16.flush = 1'b0; if16.rs = '0; if16.rt = '0;
        test_reset;
        test_mult;
        test_div;
        test_mac;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        test_w16;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
